transpose_collector: RTL and testbench

TRANSPOSE_COLLECTOR -- requirements
Module: transpose_collector

---
 rtl/transpose_collector_pkg.sv | 15 +
 rtl/transpose_collector.sv | 90 +++++++++
 tb/tb_transpose_collector.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/transpose_collector_pkg.sv
// Shared constants and element type for the systolic transpose blocks.
package transpose_collector_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_BITS  = 8;

    // One signed matrix element at the default width.
    typedef logic signed [DEFAULT_BITS-1:0] elem_t;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/transpose_collector.sv
// Serial-to-parallel collector: gathers DEPTH signed elements into one word,
// with a one-word pending stage so input can keep flowing while q is held.
module transpose_collector
    import transpose_collector_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] q [DEPTH]
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]        cnt;
    logic signed [BITS-1:0]  asm_buf [DEPTH];

    logic accept;
    logic take;
    logic slot_free;

    // Handshake decode; flush overrides any element offered in the same cycle.
    assign accept    = in_valid && in_ready && !flush;
    assign take      = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    // Ready depends on registered state only, so out_ready never ripples back.
    assign in_ready = (cnt != CNT_FULL);

    // Counter, assembly buffer and output register advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            // NOTE: the buffer and q are cleared on reset so no stale element
            // from before reset can ever be observed on q.
            for (int i = 0; i < DEPTH; i++) begin
                asm_buf[i] <= '0;
                q[i]       <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so the later branches
            // below may override this default without ordering hazards.
            if (take) begin
                out_valid <= 1'b0;
            end

            if (flush) begin
                cnt <= '0;
            end else if (cnt == CNT_FULL) begin
                // Pending word moves into q as soon as the consumer takes q.
                if (take) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        q[i] <= asm_buf[i];
                    end
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
            end else if (accept) begin
                if (cnt != CNT_LAST) begin
                    asm_buf[cnt[IDX_W-1:0]] <= din;
                    cnt                     <= cnt + CNT_W'(1);
                end else if (slot_free) begin
                    // Last element bypasses the buffer straight into q.
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        q[i] <= asm_buf[i];
                    end
                    q[DEPTH-1] <= din;
                    out_valid  <= 1'b1;
                    cnt        <= '0;
                end else begin
                    asm_buf[DEPTH-1] <= din;
                    cnt              <= CNT_FULL;
                end
            end
        end
    end

endmodule

// File: tb/tb_transpose_collector.sv
// Bench for transpose_collector: directed scenarios plus random traffic, all
// compared against a word-level queue model of the collector.
module tb_transpose_collector;
    import transpose_collector_pkg::*;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;
    localparam int WW    = DEPTH * BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    elem_t             din = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    elem_t             q [DEPTH];

    int errors = 0;
    int checks = 0;

    // Model: elements of the word being gathered, and completed words not yet
    // consumed (front = word on q, second = pending word).
    elem_t           partial [$];
    logic [WW-1:0]   outq [$];

    transpose_collector #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] q_packed();
        logic [WW-1:0] w;
        for (int k = 0; k < DEPTH; k++) w[k*BITS +: BITS] = q[k];
        return w;
    endfunction

    function automatic logic [WW-1:0] pack_list(input int base, input int stride, input bit alt);
        logic [WW-1:0] w;
        for (int k = 0; k < DEPTH; k++) begin
            int v;
            v = base + k * stride;
            if (alt && (k % 2 == 0)) v = -v;
            w[k*BITS +: BITS] = 8'(v);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level behaviour of one clock edge, from the pre-edge state.
    task automatic model_edge(input logic v, input elem_t d, input logic ordy, input logic fl);
        logic consume;
        logic rdy;
        logic [WW-1:0] w;
        consume = (outq.size() > 0) && ordy;
        rdy     = (outq.size() < 2);
        if (fl) begin
            if (outq.size() == 2) void'(outq.pop_back());
            partial.delete();
            if (consume) void'(outq.pop_front());
        end else begin
            if (consume) void'(outq.pop_front());
            if (v && rdy) begin
                partial.push_back(d);
                if (partial.size() == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) w[k*BITS +: BITS] = partial[k];
                    outq.push_back(w);
                    partial.delete();
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".out_valid"}, WW'(out_valid), WW'(outq.size() > 0));
        check({tag, ".in_ready"},  WW'(in_ready),  WW'(outq.size() < 2));
        if (outq.size() > 0) check({tag, ".q"}, q_packed(), outq[0]);
    endtask

    task automatic step(input string tag, input logic v, input elem_t d,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge(v, d, ordy, fl);
        #1;
        compare(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out_valid"}, WW'(out_valid), '0);
        check({tag, ".in_ready"},  WW'(in_ready),  WW'(1));
        check({tag, ".q"},         q_packed(),     '0);
    endtask

    initial begin
        elem_t pool [4];
        pool[0] = 8'sh80;
        pool[1] = 8'sh7F;
        pool[2] = 8'sh00;
        pool[3] = -8'sd1;

        // Reset state.
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back alternating-sign stream with out_ready held high.
        for (int i = 1; i <= DEPTH; i++)
            step("stream", 1'b1, elem_t'((i % 2 == 1) ? -i : i), 1'b1, 1'b0);
        check("stream.word", q_packed(), pack_list(1, 1, 1'b1));
        step("stream.drain", 1'b0, '0, 1'b1, 1'b0);

        // Two words with the consumer stalled, then one consumer cycle.
        for (int i = 1; i <= 2 * DEPTH; i++)
            step("stall", 1'b1, elem_t'(i), 1'b0, 1'b0);
        check("stall.in_ready_low", WW'(in_ready), '0);
        check("stall.first_word", q_packed(), pack_list(1, 1, 1'b0));
        step("stall.take", 1'b0, '0, 1'b1, 1'b0);
        check("stall.second_word", q_packed(), pack_list(9, 1, 1'b0));
        step("stall.drain", 1'b0, '0, 1'b1, 1'b0);

        // Partial word discarded by flush.
        for (int i = 0; i < 3; i++) step("flush3", 1'b1, elem_t'(50 + i), 1'b0, 1'b0);
        step("flush3.flush", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 10; i < 10 + DEPTH; i++) step("flush3.word", 1'b1, elem_t'(i), 1'b0, 1'b0);
        check("flush3.result", q_packed(), pack_list(10, 1, 1'b0));
        step("flush3.drain", 1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with the final element of a word.
        for (int i = 1; i < DEPTH; i++) step("flush8", 1'b1, elem_t'(i), 1'b1, 1'b0);
        step("flush8.flush", 1'b1, elem_t'(DEPTH), 1'b1, 1'b1);
        check("flush8.no_word", WW'(out_valid), '0);
        for (int i = 21; i < 21 + DEPTH; i++) step("flush8.word", 1'b1, elem_t'(i), 1'b0, 1'b0);
        check("flush8.result", q_packed(), pack_list(21, 1, 1'b0));
        step("flush8.drain", 1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset with a word on q and a partial word in flight.
        for (int i = 0; i < DEPTH + 5; i++) step("rstmid", 1'b1, elem_t'(100 + i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        outq.delete();
        partial.delete();
        check_reset_state("rstmid.async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) step("rstmid.clean", 1'b1, elem_t'(-40 + 3 * i), 1'b0, 1'b0);
        check("rstmid.result", q_packed(), pack_list(-40, 3, 1'b0));
        step("rstmid.take", 1'b0, '0, 1'b1, 1'b0);
        check("rstmid.single", WW'(out_valid), '0);

        // Random traffic with extreme values mixed in.
        for (int n = 0; n < 3000; n++) begin
            elem_t d;
            d = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : elem_t'($urandom);
            step("random", ($urandom_range(0, 9) < 7), d,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
        end
        for (int n = 0; n < 4; n++) step("random.drain", 1'b0, '0, 1'b1, 1'b0);
        check("random.empty", WW'(out_valid), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
